present_enc_core: RTL

Iterative PRESENT-80 encryption datapath, one round per clock. Sits directly downstream of the 80-bit key schedule block. It loads the master key into the schedule, steps the schedule once per round, and consumes its round-key register. Start/done handshake toward the crypto top level; 64-bit block in, 64-bit ciphertext out.

---
 rtl/present_enc_core_if.sv | 40 ++++
 rtl/present_enc_core.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/present_enc_core_if.sv
// Handshake, data and key-schedule signals of the PRESENT-80 encryption core.
// Optional macro PRESENT_ABORT_EN adds the abort request line.
interface present_enc_core_if #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 80
);
  logic               start;
  logic [BLOCK_W-1:0] plaintext;
  logic [KEY_W-1:0]   key;
  logic               ready;
  logic               busy;
  logic               done;
  logic [BLOCK_W-1:0] ciphertext;
  logic [KEY_W-1:0]   ks_key;
  logic               ks_load;
  logic               ks_step;
  logic [4:0]         ks_round;
  logic [KEY_W-1:0]   rk;
`ifdef PRESENT_ABORT_EN
  logic               abort;

  modport master (
    output start, plaintext, key, rk, abort,
    input  ready, busy, done, ciphertext, ks_key, ks_load, ks_step, ks_round
  );
  modport slave (
    input  start, plaintext, key, rk, abort,
    output ready, busy, done, ciphertext, ks_key, ks_load, ks_step, ks_round
  );
`else
  modport master (
    output start, plaintext, key, rk,
    input  ready, busy, done, ciphertext, ks_key, ks_load, ks_step, ks_round
  );
  modport slave (
    input  start, plaintext, key, rk,
    output ready, busy, done, ciphertext, ks_key, ks_load, ks_step, ks_round
  );
`endif
endinterface

// File: rtl/present_enc_core.sv
// Iterative PRESENT-80 encryption datapath, one round per clock, driving an external key schedule.
// Optional macro PRESENT_ABORT_EN enables the abort input (cancel an encryption in flight).
module present_enc_core #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 80,
  parameter int ROUNDS  = 31
) (
  input logic              clk,
  input logic              rst,
  present_enc_core_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  state_t             fsm_r, fsm_next_s;
  logic [BLOCK_W-1:0] blk_r, blk_next_s;
  logic [4:0]         round_r, round_next_s;
  logic [BLOCK_W-1:0] ct_r, ct_next_s;
  logic               done_r, done_next_s;
  logic               ready_r;
  logic               busy_r;
  logic               ks_load_s;
  logic               ks_step_s;
  logic [4:0]         ks_round_s;
  logic               abort_s;
  logic [BLOCK_W-1:0] round_key_s;
  logic [BLOCK_W-1:0] round_out_s;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i lands at (16*i) mod 63; the top bit is a fixed point of the permutation.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      y[(i * (BLOCK_W / 4)) % (BLOCK_W - 1)] = x[i];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

`ifdef PRESENT_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign round_key_s = bus.rk[KEY_W-1 -: BLOCK_W];
  assign round_out_s = p_layer(s_layer(blk_r ^ round_key_s));

  // Next-state, datapath and key-schedule control decode.
  always_comb begin
    fsm_next_s   = fsm_r;
    blk_next_s   = blk_r;
    round_next_s = round_r;
    ct_next_s    = ct_r;
    done_next_s  = 1'b0;
    ks_load_s    = 1'b0;
    ks_step_s    = 1'b0;
    ks_round_s   = 5'd0;
    case (fsm_r)
      ST_IDLE: begin
        if (bus.start) begin
          ks_load_s    = 1'b1;
          blk_next_s   = bus.plaintext;
          round_next_s = 5'd1;
          fsm_next_s   = ST_ROUND;
        end else begin
          fsm_next_s   = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (abort_s) begin
          fsm_next_s   = ST_IDLE;
          blk_next_s   = '0;
          round_next_s = 5'd0;
        end else begin
          blk_next_s = round_out_s;
          ks_step_s  = 1'b1;
          ks_round_s = round_r - 5'd1;
          if (round_r == 5'(ROUNDS)) begin
            round_next_s = 5'd0;
            fsm_next_s   = ST_FINAL;
          end else begin
            round_next_s = round_r + 5'd1;
            fsm_next_s   = ST_ROUND;
          end
        end
      end
      ST_FINAL: begin
        if (abort_s) begin
          fsm_next_s   = ST_IDLE;
          blk_next_s   = '0;
          round_next_s = 5'd0;
        end else begin
          // Final key whitening with K32; no S-box/permutation on this step.
          ct_next_s   = blk_r ^ round_key_s;
          done_next_s = 1'b1;
          blk_next_s  = '0;
          fsm_next_s  = ST_IDLE;
        end
      end
      default: begin
        fsm_next_s   = ST_IDLE;
        blk_next_s   = '0;
        round_next_s = 5'd0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= ST_IDLE;
      blk_r   <= '0;
      round_r <= 5'd0;
      ct_r    <= '0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_next_s;
      blk_r   <= blk_next_s;
      round_r <= round_next_s;
      ct_r    <= ct_next_s;
      done_r  <= done_next_s;
      ready_r <= (fsm_next_s == ST_IDLE);
      busy_r  <= (fsm_next_s != ST_IDLE);
    end
  end

  assign bus.ready      = ready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ciphertext = ct_r;
  assign bus.ks_key     = bus.key;
  assign bus.ks_load    = ks_load_s;
  assign bus.ks_step    = ks_step_s;
  assign bus.ks_round   = ks_round_s;

endmodule
